// File: rtl/prbs_pkg.sv
// Shared PRBS31 definitions: polynomial x^31 + x^28 + 1, tap positions,
// receiver state encoding and the predicted-bit helper. The generator side
// imports the same package so both ends agree on the sequence.
package prbs_pkg;

  localparam int PRBS_W     = 31;
  localparam int PRBS_TAP_A = 30;
  localparam int PRBS_TAP_B = 27;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } prbs_state_e;

  // Next bit of the sequence given the last 31 bits (s[0] is the newest).
  function automatic logic prbs_predict(input logic [PRBS_W-1:0] s);
    return s[PRBS_TAP_A] ^ s[PRBS_TAP_B];
  endfunction

endpackage

// File: rtl/prbs31_step.sv
// One step of the PRBS31 LFSR. Produces the predicted next bit and the
// shifted register. free_run selects the feed: the predicted bit (free
// running, errors do not propagate) or an external bit (self-synchronising).
module prbs31_step
  import prbs_pkg::*;
(
  input  logic [PRBS_W-1:0] s,
  input  logic              free_run,
  input  logic              ext_bit,
  output logic              p,
  output logic [PRBS_W-1:0] s_next
);

  logic feed;

  // Predict the next bit and shift the chosen feed bit in at the bottom.
  always_comb begin
    p      = prbs_predict(s);
    feed   = free_run ? p : ext_bit;
    s_next = {s[PRBS_W-2:0], feed};
  end

endmodule

// File: rtl/prbs31_ber_monitor.sv
// PRBS31 bit-error-rate monitor. Self-synchronises a local LFSR to the
// received stream (HUNT -> VERIFY -> LOCKED), then counts compared bits and
// mismatches with saturating counters. A sliding tally over fixed windows of
// valid bits detects loss of lock and sends the receiver back to HUNT.
module prbs31_ber_monitor
  import prbs_pkg::*;
#(
  parameter int VERIFY_LEN  = 32,
  parameter int LOSS_WINDOW = 64,
  parameter int LOSS_THRESH = 8,
  parameter int ERR_W       = 16,
  parameter int BIT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_bit,
  input  logic             rx_valid,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [BIT_W-1:0] bit_count
);

  localparam int FILL_W = 5;
  localparam int VER_W  = $clog2(VERIFY_LEN + 1);
  localparam int WIN_W  = (LOSS_WINDOW > 1) ? $clog2(LOSS_WINDOW) : 1;
  localparam int TAL_W  = $clog2(LOSS_THRESH + 1);

  prbs_state_e       state_q, state_d;
  logic [PRBS_W-1:0] s_q, s_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [VER_W-1:0]  ver_q, ver_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic [TAL_W-1:0]  tally_q, tally_d;
  logic [ERR_W-1:0]  err_count_q, err_count_d;
  logic [BIT_W-1:0]  bit_count_q, bit_count_d;
  logic              locked_q, locked_d;
  logic              err_pulse_q, err_pulse_d;

  logic              pred;
  logic [PRBS_W-1:0] s_step;
  logic              mismatch;
  logic              count_bit;
  logic              count_err;

  prbs31_step u_step (
    .s        (s_q),
    .free_run (state_q == LOCKED),
    .ext_bit  (rx_bit),
    .p        (pred),
    .s_next   (s_step)
  );

  assign mismatch = rx_bit ^ pred;

  // Receiver state machine, window tracking and counter next-state logic;
  // nothing moves unless a valid bit is sampled, except the counter clear.
  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    fill_d      = fill_q;
    ver_d       = ver_q;
    win_d       = win_q;
    tally_d     = tally_q;
    err_count_d = err_count_q;
    bit_count_d = bit_count_q;
    count_bit   = 1'b0;
    count_err   = 1'b0;

    if (rx_valid) begin
      s_d = s_step;
      case (state_q)
        HUNT: begin
          // The 31st fill bit completes the register; an all-zero fill is
          // the LFSR lock-up state and can never verify, so refill instead.
          if (fill_q == FILL_W'(PRBS_W - 1)) begin
            fill_d = '0;
            if (s_step != '0) begin
              state_d = VERIFY;
              ver_d   = '0;
            end
          end else begin
            fill_d = fill_q + 1'b1;
          end
        end

        VERIFY: begin
          if (mismatch) begin
            state_d = HUNT;
            fill_d  = '0;
            ver_d   = '0;
          end else if (ver_q == VER_W'(VERIFY_LEN - 1)) begin
            state_d = LOCKED;
            ver_d   = '0;
            win_d   = '0;
            tally_d = '0;
          end else begin
            ver_d = ver_q + 1'b1;
          end
        end

        LOCKED: begin
          count_bit = 1'b1;
          count_err = mismatch;
          // Loss takes priority over the window wrap so a threshold error
          // landing on the last window bit still drops lock.
          if (mismatch && (tally_q == TAL_W'(LOSS_THRESH - 1))) begin
            state_d = HUNT;
            fill_d  = '0;
            win_d   = '0;
            tally_d = '0;
          end else if (win_q == WIN_W'(LOSS_WINDOW - 1)) begin
            win_d   = '0;
            tally_d = '0;
          end else begin
            win_d   = win_q + 1'b1;
            tally_d = tally_q + TAL_W'(mismatch);
          end
        end

        default: begin
          state_d = HUNT;
          fill_d  = '0;
          ver_d   = '0;
          win_d   = '0;
          tally_d = '0;
        end
      endcase
    end

    // Clear beats any same-cycle count event; counters stick at all-ones.
    if (clear) begin
      err_count_d = '0;
      bit_count_d = '0;
    end else begin
      if (count_err && (err_count_q != '1)) err_count_d = err_count_q + 1'b1;
      if (count_bit && (bit_count_q != '1)) bit_count_d = bit_count_q + 1'b1;
    end

    err_pulse_d = count_err & ~clear;
    locked_d    = (state_d == LOCKED);
  end

  // Single state register for the FSM, LFSR, window and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      s_q         <= '0;
      fill_q      <= '0;
      ver_q       <= '0;
      win_q       <= '0;
      tally_q     <= '0;
      err_count_q <= '0;
      bit_count_q <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      fill_q      <= fill_d;
      ver_q       <= ver_d;
      win_q       <= win_d;
      tally_q     <= tally_d;
      err_count_q <= err_count_d;
      bit_count_q <= bit_count_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;
  assign bit_count = bit_count_q;

endmodule

// File: tb/tb_prbs31_ber_monitor.sv
// Directed testbench for prbs31_ber_monitor. A reference PRBS31 generator
// seeded with 1 drives the stream; expected values are hand-derived cycle
// counts (31 fill + 32 verify = lock after the 63rd valid bit). A second
// instance with a 4-bit error counter shares the stimulus for saturation.
module tb_prbs31_ber_monitor;

  logic        clk;
  logic        rst_n;
  logic        rx_bit;
  logic        rx_valid;
  logic        clear;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;
  logic [31:0] bit_count;
  logic        locked_s;
  logic        err_pulse_s;
  logic [3:0]  err_count_s;
  logic [31:0] bit_count_s;

  logic [30:0] gen_s;
  int          check_count;
  int          fail_count;
  int          pulse_total;
  int          locked_cycles;

  prbs31_ber_monitor dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_bit    (rx_bit),
    .rx_valid  (rx_valid),
    .clear     (clear),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .bit_count (bit_count)
  );

  prbs31_ber_monitor #(.ERR_W(4)) dut_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_bit    (rx_bit),
    .rx_valid  (rx_valid),
    .clear     (clear),
    .locked    (locked_s),
    .err_pulse (err_pulse_s),
    .err_count (err_count_s),
    .bit_count (bit_count_s)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and return at the next
  // falling edge, after the rising edge has sampled them.
  task automatic applyStimulus(input logic b, input logic v, input logic c);
    rx_bit   = b;
    rx_valid = v;
    clear    = c;
    @(negedge clk);
    if (err_pulse === 1'b1) pulse_total++;
    if (locked === 1'b1) locked_cycles++;
  endtask

  task automatic sendPrbs(input logic invert, input logic c);
    logic b;
    b     = gen_s[27] ^ gen_s[30];
    gen_s = {gen_s[29:0], b};
    applyStimulus(b ^ invert, 1'b1, c);
  endtask

  task automatic sendClean(input int n);
    for (int i = 0; i < n; i++) sendPrbs(1'b0, 1'b0);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    gen_s = 31'd1;
  endtask

  initial begin
    check_count   = 0;
    fail_count    = 0;
    pulse_total   = 0;
    locked_cycles = 0;
    gen_s         = 31'd1;
    rst_n         = 1'b0;
    rx_bit        = 1'b0;
    rx_valid      = 1'b0;
    clear         = 1'b0;
    @(negedge clk);

    $display("[TB] reset state");
    doReset();
    checkOutput("rst_locked", locked, 0);
    checkOutput("rst_err_pulse", err_pulse, 0);
    checkOutput("rst_err_count", err_count, 0);
    checkOutput("rst_bit_count", bit_count, 0);

    $display("[TB] clean lock");
    sendClean(62);
    checkOutput("lock_not_yet", locked, 0);
    sendClean(1);
    checkOutput("lock_at_63", locked, 1);
    checkOutput("lock_bit_count0", bit_count, 0);
    pulse_total = 0;
    sendClean(1000);
    checkOutput("clean_err_count", err_count, 0);
    checkOutput("clean_bit_count", bit_count, 1000);
    checkOutput("clean_no_pulses", pulse_total, 0);

    $display("[TB] single error");
    pulse_total = 0;
    sendPrbs(1'b1, 1'b0);
    checkOutput("single_pulse", err_pulse, 1);
    checkOutput("single_err_count", err_count, 1);
    sendClean(1);
    checkOutput("single_pulse_drop", err_pulse, 0);
    sendClean(100);
    checkOutput("single_one_pulse", pulse_total, 1);
    checkOutput("single_err_hold", err_count, 1);
    checkOutput("single_still_locked", locked, 1);
    checkOutput("single_bit_count", bit_count, 1102);

    $display("[TB] loss of lock");
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("clear_err_count", err_count, 0);
    checkOutput("clear_bit_count", bit_count, 0);
    checkOutput("clear_keeps_lock", locked, 1);
    for (int i = 0; i < 7; i++) sendPrbs(1'b1, 1'b0);
    checkOutput("loss_seven_locked", locked, 1);
    checkOutput("loss_seven_count", err_count, 7);
    sendPrbs(1'b1, 1'b0);
    checkOutput("loss_eighth_unlock", locked, 0);
    checkOutput("loss_err_count", err_count, 8);
    sendClean(62);
    checkOutput("relock_not_yet", locked, 0);
    sendClean(1);
    checkOutput("relock_at_63", locked, 1);
    checkOutput("relock_err_count", err_count, 8);

    $display("[TB] asynchronous reset mid-stream");
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_locked", locked, 0);
    checkOutput("async_err_count", err_count, 0);
    checkOutput("async_bit_count", bit_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] all-zero stream");
    doReset();
    locked_cycles = 0;
    for (int i = 0; i < 500; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("zero_never_locked", locked_cycles, 0);
    checkOutput("zero_err_count", err_count, 0);
    checkOutput("zero_bit_count", bit_count, 0);

    $display("[TB] valid gaps and clear");
    doReset();
    for (int i = 0; i < 62; i++) begin
      sendPrbs(1'b0, 1'b0);
      applyStimulus(1'($urandom_range(1, 0)), 1'b0, 1'b0);
    end
    checkOutput("gap_not_yet", locked, 0);
    sendPrbs(1'b0, 1'b0);
    checkOutput("gap_lock_at_63", locked, 1);
    applyStimulus(1'($urandom_range(1, 0)), 1'b0, 1'b0);
    checkOutput("gap_hold_lock", locked, 1);
    checkOutput("gap_hold_bits", bit_count, 0);
    sendClean(10);
    sendPrbs(1'b1, 1'b0);
    checkOutput("gap_err_before", err_count, 1);
    checkOutput("gap_bits_before", bit_count, 11);
    sendPrbs(1'b1, 1'b1);
    checkOutput("clear_wins_err", err_count, 0);
    checkOutput("clear_wins_bits", bit_count, 0);
    checkOutput("clear_wins_pulse", err_pulse, 0);

    $display("[TB] saturation");
    doReset();
    sendClean(63);
    checkOutput("sat_locked", locked_s, 1);
    for (int i = 0; i < 20; i++) begin
      sendPrbs(1'b1, 1'b0);
      sendClean(15);
    end
    checkOutput("sat_err_count", err_count_s, 15);
    checkOutput("wide_err_count", err_count, 20);
    checkOutput("sat_bit_count", bit_count_s, 320);
    checkOutput("sat_still_locked", locked_s, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
    $finish;
  end

endmodule
